// File: rtl/bit_serial_addsub_ctrl.sv
// Bit-serial WIDTH-bit add/subtract: one full-adder evaluation per clock, LSB first,
// sequenced by an IDLE/RUN/DONE handshake FSM with carry, overflow and zero flags.
module bit_serial_addsub_ctrl #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int            CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic              accept, last_bit;
  logic [WIDTH-1:0]  a_sh, b_sh, result_q, result_nxt;
  logic [CW-1:0]     count;
  logic              carry, c_msb_in;
  logic              c_out_q, overflow_q, zero_q;
  logic              fa_sum, fa_cout;

  // The single full-adder slice the whole operation is time-multiplexed through.
  assign fa_sum     = a_sh[0] ^ b_sh[0] ^ carry;
  assign fa_cout    = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  assign result_nxt = {fa_sum, result_q[WIDTH-1:1]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_bit  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (count == LAST) begin
          last_bit  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the shift registers are plain flops rather than a memory array, so
  // they are all reset; abort mid-RUN must leave nothing visible behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      result_q   <= '0;
      count      <= '0;
      carry      <= 1'b0;
      c_msb_in   <= 1'b0;
      c_out_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else if (accept) begin
      // Subtraction is a + ~b + 1: the +1 rides in as the initial carry.
      a_sh       <= a;
      b_sh       <= sub ? ~b : b;
      carry      <= sub;
      count      <= '0;
      c_out_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else if (state == RUN) begin
      a_sh     <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh     <= {1'b0, b_sh[WIDTH-1:1]};
      result_q <= result_nxt;
      carry    <= fa_cout;
      if (!last_bit) count <= count + CW'(1);
      if (count == PENULT) c_msb_in <= fa_cout;
      if (last_bit) begin
        c_out_q    <= fa_cout;
        overflow_q <= c_msb_in ^ fa_cout;
        zero_q     <= (result_nxt == '0);
      end
    end
  end

  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign result   = result_q;
  assign c_out    = c_out_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_bit_serial_addsub_ctrl.sv
// Randomized and directed bench for bit_serial_addsub_ctrl (WIDTH=64 and WIDTH=8),
// checked against an arithmetic reference model.
module tb_bit_serial_addsub_ctrl;

  localparam int W  = 64;
  localparam int W8 = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, sub;
  logic [W-1:0]  a, b, result;
  logic          busy, done, c_out, overflow, zero;

  logic          s_start, s_sub;
  logic [W8-1:0] s_a, s_b, s_result;
  logic          s_busy, s_done, s_c_out, s_overflow, s_zero;

  int errors = 0;
  int checks = 0;

  bit_serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .c_out(c_out),
    .overflow(overflow), .zero(zero)
  );

  bit_serial_addsub_ctrl #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .sub(s_sub), .a(s_a), .b(s_b),
    .busy(s_busy), .done(s_done), .result(s_result), .c_out(s_c_out),
    .overflow(s_overflow), .zero(s_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] r;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  typedef struct {
    logic [63:0] x;
    logic [63:0] y;
    logic        s;
  } vec_t;

  // Reference: modular arithmetic with unsigned carry/borrow and signed overflow by sign rules.
  function automatic exp_t model(input int w, input logic [63:0] x, input logic [63:0] y,
                                 input logic s);
    exp_t        e;
    logic [64:0] mask, full;
    logic [63:0] xm, ym;
    mask = (65'd1 << w) - 65'd1;
    xm   = x & mask[63:0];
    ym   = y & mask[63:0];
    if (s) begin
      e.r = (xm - ym) & mask[63:0];
      e.c = (xm >= ym);
      e.v = (xm[w-1] != ym[w-1]) && (e.r[w-1] != xm[w-1]);
    end else begin
      full = {1'b0, xm} + {1'b0, ym};
      e.r  = full[63:0] & mask[63:0];
      e.c  = full[w];
      e.v  = (xm[w-1] == ym[w-1]) && (e.r[w-1] != xm[w-1]);
    end
    e.z = (e.r == 64'd0);
    return e;
  endfunction

  task automatic launch(input logic [63:0] x, input logic [63:0] y, input logic s);
    @(negedge clk);
    a = x; b = y; sub = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done; counts busy cycles and protocol violations seen on the way.
  task automatic wait_done(output int lat, output int busy_cnt, output int bad);
    lat = 0; busy_cnt = 0; bad = 0;
    while (done !== 1'b1 && lat < 4 * W) begin
      if (busy === 1'b1) busy_cnt++;
      if (busy === 1'b1 && (c_out !== 1'b0 || overflow !== 1'b0 || zero !== 1'b0)) bad++;
      @(negedge clk);
      lat++;
    end
    if (busy === 1'b1 && done === 1'b1) bad++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    s_start = 1'b0; s_sub = 1'b0; s_a = '0; s_b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, c_out, overflow, zero, result} !== '0) begin
      errors++;
      $display("FAIL reset_w64: got busy=%b done=%b res=%h c=%b v=%b z=%b, expected all 0",
               busy, done, result, c_out, overflow, zero);
    end
    checks++;
    if ({s_busy, s_done, s_c_out, s_overflow, s_zero, s_result} !== '0) begin
      errors++;
      $display("FAIL reset_w8: got busy=%b done=%b res=%h, expected all 0",
               s_busy, s_done, s_result);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    vec_t vecs[4];
    exp_t e;
    int   lat, bcnt, bad;
    logic [W-1:0] held;
    vecs[0] = '{64'd5, 64'd7, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0};
    vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0};
    vecs[3] = '{64'd3, 64'd5, 1'b1};
    for (int i = 0; i < 4; i++) begin
      e = model(W, vecs[i].x, vecs[i].y, vecs[i].s);
      launch(vecs[i].x, vecs[i].y, vecs[i].s);
      wait_done(lat, bcnt, bad);
      checks++;
      if (lat !== W || bcnt !== W || bad !== 0) begin
        errors++;
        $display("FAIL dir%0d_timing: got lat=%0d busy=%0d viol=%0d, expected %0d %0d 0",
                 i, lat, bcnt, bad, W, W);
      end
      checks++;
      if (result !== e.r || c_out !== e.c || overflow !== e.v || zero !== e.z) begin
        errors++;
        $display("FAIL dir%0d_value: got r=%h c=%b v=%b z=%b, expected r=%h c=%b v=%b z=%b",
                 i, result, c_out, overflow, zero, e.r, e.c, e.v, e.z);
      end
      held = result;
      repeat (3) @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== held || zero !== e.z || c_out !== e.c) begin
        errors++;
        $display("FAIL dir%0d_hold: got done=%b busy=%b r=%h, expected 0 0 %h",
                 i, done, busy, result, held);
      end
    end
  endtask

  task automatic test_random();
    exp_t        e;
    int          lat, bcnt, bad;
    logic [63:0] x, y;
    logic        s;
    for (int i = 0; i < 12; i++) begin
      x = {$urandom, $urandom};
      y = (i % 5 == 4) ? x : {$urandom, $urandom};
      s = 1'($urandom);
      e = model(W, x, y, s);
      launch(x, y, s);
      wait_done(lat, bcnt, bad);
      checks++;
      if (lat !== W || bad !== 0 || result !== e.r || c_out !== e.c ||
          overflow !== e.v || zero !== e.z) begin
        errors++;
        $display("FAIL rnd%0d: got lat=%0d viol=%0d r=%h c=%b v=%b z=%b, expected lat=%0d r=%h c=%b v=%b z=%b",
                 i, lat, bad, result, c_out, overflow, zero, W, e.r, e.c, e.v, e.z);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   j;
    e = model(W, 64'd9, 64'd9, 1'b1);
    @(negedge clk);
    a = 64'd9; b = 64'd9; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    for (int op = 0; op < 3; op++) begin
      j = 0;
      while (done !== 1'b1 && j < 4 * W) begin
        if (j == 10) begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = 1'b0; end
        if (j == 40) begin a = 64'd9; b = 64'd9; sub = 1'b1; end
        @(negedge clk);
        j++;
      end
      checks++;
      if (j !== W) begin
        errors++;
        $display("FAIL b2b%0d_period: got %0d cycles between dones, expected %0d", op, j + 1, W + 1);
      end
      checks++;
      if (result !== e.r || zero !== 1'b1 || c_out !== 1'b1 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL b2b%0d_value: got r=%h z=%b c=%b v=%b, expected r=0 z=1 c=1 v=0",
                 op, result, zero, c_out, overflow);
      end
      if (op == 2) start = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_release: got busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t        e;
    int          lat, bcnt, bad, dones;
    logic [63:0] x, y;
    launch(64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 1'b0);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, c_out, overflow, zero, result} !== '0) begin
      errors++;
      $display("FAIL abort_clear: got busy=%b done=%b r=%h c=%b v=%b z=%b, expected all 0",
               busy, done, result, c_out, overflow, zero);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < W + 16; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses, expected 0", dones);
    end
    x = {$urandom, $urandom};
    y = {$urandom, $urandom};
    e = model(W, x, y, 1'b1);
    launch(x, y, 1'b1);
    wait_done(lat, bcnt, bad);
    checks++;
    if (lat !== W || result !== e.r || c_out !== e.c || overflow !== e.v || zero !== e.z) begin
      errors++;
      $display("FAIL abort_recover: got lat=%0d r=%h c=%b v=%b z=%b, expected lat=%0d r=%h c=%b v=%b z=%b",
               lat, result, c_out, overflow, zero, W, e.r, e.c, e.v, e.z);
    end
  endtask

  task automatic test_width8();
    exp_t       e;
    int         j;
    logic [7:0] x, y;
    logic       s;
    for (int i = 0; i < 6; i++) begin
      x = (i == 0) ? 8'h80 : 8'($urandom);
      y = (i == 0) ? 8'h01 : 8'($urandom);
      s = (i == 0) ? 1'b1 : 1'($urandom);
      e = model(W8, {56'd0, x}, {56'd0, y}, s);
      @(negedge clk);
      s_a = x; s_b = y; s_sub = s; s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      j = 0;
      while (s_done !== 1'b1 && j < 4 * W8) begin
        @(negedge clk);
        j++;
      end
      checks++;
      if (j !== W8 || s_busy !== 1'b0 || s_result !== e.r[7:0] || s_c_out !== e.c ||
          s_overflow !== e.v || s_zero !== e.z) begin
        errors++;
        $display("FAIL w8_%0d: got lat=%0d r=%h c=%b v=%b z=%b, expected lat=%0d r=%h c=%b v=%b z=%b",
                 i, j + 1, s_result, s_c_out, s_overflow, s_zero, W8 + 1, e.r[7:0], e.c, e.v, e.z);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    test_width8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
